// File: rtl/ysyx_23060075_lsu_pkg.sv
// Shared LSU configuration: datapath width and RV funct3 load/store encodings,
// plus the FSM state type and the op-legality check used by the LSU top.
`ifndef YSYX_23060075_CONFIG_VH
`define YSYX_23060075_CONFIG_VH
`define ysyx_23060075_ISA_WIDTH 32
`define ysyx_23060075_F3_LB  3'd0
`define ysyx_23060075_F3_LH  3'd1
`define ysyx_23060075_F3_LW  3'd2
`define ysyx_23060075_F3_LBU 3'd4
`define ysyx_23060075_F3_LHU 3'd5
`define ysyx_23060075_F3_SB  3'd0
`define ysyx_23060075_F3_SH  3'd1
`define ysyx_23060075_F3_SW  3'd2
`endif

package ysyx_23060075_lsu_pkg;

   localparam logic [2:0] F3_LB  = `ysyx_23060075_F3_LB;
   localparam logic [2:0] F3_LH  = `ysyx_23060075_F3_LH;
   localparam logic [2:0] F3_LW  = `ysyx_23060075_F3_LW;
   localparam logic [2:0] F3_LBU = `ysyx_23060075_F3_LBU;
   localparam logic [2:0] F3_LHU = `ysyx_23060075_F3_LHU;
   localparam logic [2:0] F3_SB  = `ysyx_23060075_F3_SB;
   localparam logic [2:0] F3_SH  = `ysyx_23060075_F3_SH;
   localparam logic [2:0] F3_SW  = `ysyx_23060075_F3_SW;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   // Conflicting load+store, reserved funct3, or a halfword/word access that
   // does not sit on its natural boundary.
   function automatic logic op_illegal(input logic       ren,
                                       input logic       wen,
                                       input logic [2:0] funct,
                                       input logic [1:0] addr_lo);
      logic err;
      err = 1'b0;
      if (ren && wen) begin
         err = 1'b1;
      end else if (ren) begin
         case (funct)
            F3_LB, F3_LBU: err = 1'b0;
            F3_LH, F3_LHU: err = addr_lo[0];
            F3_LW:         err = (addr_lo != 2'b00);
            default:       err = 1'b1;
         endcase
      end else if (wen) begin
         case (funct)
            F3_SB:   err = 1'b0;
            F3_SH:   err = addr_lo[0];
            F3_SW:   err = (addr_lo != 2'b00);
            default: err = 1'b1;
         endcase
      end
      return err;
   endfunction

endpackage

// File: rtl/ysyx_23060075_lsu_align.sv
// Byte-lane steering: store mask/replication on the way out, load lane
// extraction with sign/zero extension on the way back.
module ysyx_23060075_lsu_align
   import ysyx_23060075_lsu_pkg::*;
#(
   parameter int ISA_W  = `ysyx_23060075_ISA_WIDTH,
   parameter int MASK_W = ISA_W / 8
) (
   input  logic [2:0]        funct,
   input  logic [1:0]        addr_lo,
   input  logic [ISA_W-1:0]  src2,
   input  logic [ISA_W-1:0]  rdata,
   output logic [MASK_W-1:0] wmask,
   output logic [ISA_W-1:0]  wdata,
   output logic [ISA_W-1:0]  load_data
);

   logic [ISA_W-1:0] lane;

   assign lane = rdata >> {addr_lo, 3'b000};

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      wmask     = '0;
      wdata     = '0;
      load_data = '0;
      case (funct)
         F3_LB: begin
            wmask     = MASK_W'(1) << addr_lo;
            wdata     = {(ISA_W/8){src2[7:0]}};
            load_data = {{(ISA_W-8){lane[7]}}, lane[7:0]};
         end
         F3_LH: begin
            wmask     = MASK_W'(3) << addr_lo;
            wdata     = {(ISA_W/16){src2[15:0]}};
            load_data = {{(ISA_W-16){lane[15]}}, lane[15:0]};
         end
         F3_LW: begin
            wmask     = '1;
            wdata     = src2;
            load_data = lane;
         end
         F3_LBU:  load_data = {{(ISA_W-8){1'b0}}, lane[7:0]};
         F3_LHU:  load_data = {{(ISA_W-16){1'b0}}, lane[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/ysyx_23060075_lsu.sv
// Load/store unit: accepts one op from execute, runs at most one bus
// transaction, and hands a single writeback result to the next stage.
module ysyx_23060075_lsu
   import ysyx_23060075_lsu_pkg::*;
#(
   parameter int ISA_W  = `ysyx_23060075_ISA_WIDTH,
   parameter int MASK_W = ISA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              mem_ren,
   input  logic              mem_wen,
   input  logic [2:0]        mem_funct,
   input  logic [ISA_W-1:0]  alu_result,
   input  logic [ISA_W-1:0]  src2,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ISA_W-1:0]  bus_addr,
   output logic [ISA_W-1:0]  bus_wdata,
   output logic [MASK_W-1:0] bus_wmask,
   input  logic              bus_ack,
   input  logic [ISA_W-1:0]  bus_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ISA_W-1:0]  wb_data,
   output logic              lsu_err
);

   lsu_state_e        state_q, state_d;
   logic              is_load_q;
   logic [2:0]        funct_q;
   logic [1:0]        addr_lo_q;
   logic              accept;
   logic              is_mem;
   logic              op_err;
   logic              bus_done;
   logic [2:0]        funct_sel;
   logic [1:0]        addr_lo_sel;
   logic [MASK_W-1:0] al_wmask;
   logic [ISA_W-1:0]  al_wdata;
   logic [ISA_W-1:0]  al_load;

   assign accept   = (state_q == ST_IDLE) && in_valid;
   assign is_mem   = mem_ren || mem_wen;
   assign op_err   = op_illegal(mem_ren, mem_wen, mem_funct, alu_result[1:0]);
   assign bus_done = (state_q == ST_BUS) && bus_ack;

   // One aligner serves both directions: live inputs while accepting, the
   // registered op while waiting for read data.
   assign funct_sel   = (state_q == ST_IDLE) ? mem_funct        : funct_q;
   assign addr_lo_sel = (state_q == ST_IDLE) ? alu_result[1:0]  : addr_lo_q;

   ysyx_23060075_lsu_align #(
      .ISA_W  (ISA_W),
      .MASK_W (MASK_W)
   ) u_align (
      .funct     (funct_sel),
      .addr_lo   (addr_lo_sel),
      .src2      (src2),
      .rdata     (bus_rdata),
      .wmask     (al_wmask),
      .wdata     (al_wdata),
      .load_data (al_load)
   );

   assign in_ready  = (state_q == ST_IDLE);
   assign bus_req   = (state_q == ST_BUS);
   assign out_valid = (state_q == ST_DONE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid) state_d = (is_mem && !op_err) ? ST_BUS : ST_DONE;
         ST_BUS:  if (bus_ack)  state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         is_load_q <= 1'b0;
         funct_q   <= 3'd0;
         addr_lo_q <= 2'b00;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wmask <= '0;
         wb_data   <= '0;
         lsu_err   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            is_load_q <= mem_ren;
            funct_q   <= mem_funct;
            addr_lo_q <= alu_result[1:0];
            if (!is_mem) begin
               wb_data <= alu_result;
               lsu_err <= 1'b0;
            end else if (op_err) begin
               wb_data <= '0;
               lsu_err <= 1'b1;
            end else begin
               wb_data   <= '0;
               lsu_err   <= 1'b0;
               bus_addr  <= {alu_result[ISA_W-1:2], 2'b00};
               bus_we    <= mem_wen;
               bus_wdata <= mem_wen ? al_wdata : '0;
               bus_wmask <= mem_wen ? al_wmask : '0;
            end
         end
         if (bus_done) begin
            wb_data <= is_load_q ? al_load : '0;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060075_lsu.sv
// Directed bench for the LSU: loads, stores, errors, writeback back-pressure
// and reset during an outstanding bus request.
module tb_ysyx_23060075_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        mem_ren;
   logic        mem_wen;
   logic [2:0]  mem_funct;
   logic [31:0] alu_result;
   logic [31:0] src2;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wmask;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] wb_data;
   logic        lsu_err;

   int checks = 0;
   int errors = 0;

   ysyx_23060075_lsu dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .mem_ren    (mem_ren),
      .mem_wen    (mem_wen),
      .mem_funct  (mem_funct),
      .alu_result (alu_result),
      .src2       (src2),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_wmask  (bus_wmask),
      .bus_ack    (bus_ack),
      .bus_rdata  (bus_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .wb_data    (wb_data),
      .lsu_err    (lsu_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic issue(input logic ren, input logic wen, input logic [2:0] f,
                        input logic [31:0] addr, input logic [31:0] data);
      in_valid   = 1'b1;
      mem_ren    = ren;
      mem_wen    = wen;
      mem_funct  = f;
      alu_result = addr;
      src2       = data;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_funct = 3'd0;
      alu_result = '0; src2 = '0; bus_ack = 1'b0; bus_rdata = '0; out_ready = 1'b1;
      #1;
      check("rst_bus_req",   {31'd0, bus_req},   32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_lsu_err",   {31'd0, lsu_err},   32'd0);
      check("rst_wb_data",   wb_data,            32'd0);
      check("rst_bus_addr",  bus_addr,           32'd0);
      check("rst_wmask",     {28'd0, bus_wmask}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      step();
      step();
      rst = 1'b0;
      step();

      // LB from the top byte lane, ack in the first BUS cycle.
      issue(1'b1, 1'b0, 3'd0, 32'h8000_0003, 32'd0);
      check("lb_bus_req",  {31'd0, bus_req}, 32'd1);
      check("lb_bus_we",   {31'd0, bus_we},  32'd0);
      check("lb_bus_addr", bus_addr,         32'h8000_0000);
      check("lb_in_ready", {31'd0, in_ready}, 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'h80FF_FF00;
      step();
      bus_ack = 1'b0;
      check("lb_out_valid", {31'd0, out_valid}, 32'd1);
      check("lb_wb_data",   wb_data,            32'hFFFF_FF80);
      check("lb_err",       {31'd0, lsu_err},   32'd0);
      check("lb_req_drop",  {31'd0, bus_req},   32'd0);
      step();
      check("lb_back_idle", {31'd0, in_ready},  32'd1);

      // Stray ack while idle must not produce a result.
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      check("idle_ack_ignored", {31'd0, out_valid}, 32'd0);

      // SH to upper half, ack delayed two cycles.
      issue(1'b0, 1'b1, 3'd1, 32'h8000_0002, 32'h1234_ABCD);
      check("sh_bus_we",    {31'd0, bus_we},    32'd1);
      check("sh_wmask",     {28'd0, bus_wmask}, 32'h0000_000C);
      check("sh_wdata",     bus_wdata,          32'hABCD_ABCD);
      check("sh_bus_addr",  bus_addr,           32'h8000_0000);
      step();
      step();
      check("sh_req_held",  {31'd0, bus_req},   32'd1);
      check("sh_wdata_held", bus_wdata,         32'hABCD_ABCD);
      check("sh_wmask_held", {28'd0, bus_wmask}, 32'h0000_000C);
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      check("sh_out_valid", {31'd0, out_valid}, 32'd1);
      check("sh_wb_zero",   wb_data,            32'd0);
      step();

      // SB into lane 3.
      issue(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5);
      check("sb_wmask", {28'd0, bus_wmask}, 32'h0000_0008);
      check("sb_wdata", bus_wdata,          32'hA5A5_A5A5);
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      step();

      // SW aligned.
      issue(1'b0, 1'b1, 3'd2, 32'h0000_2004, 32'hDEAD_BEEF);
      check("sw_wmask", {28'd0, bus_wmask}, 32'h0000_000F);
      check("sw_wdata", bus_wdata,          32'hDEAD_BEEF);
      check("sw_addr",  bus_addr,           32'h0000_2004);
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      step();

      // LHU upper half: zero-extended.
      issue(1'b1, 1'b0, 3'd5, 32'h0000_3002, 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'h8001_1234;
      step();
      bus_ack = 1'b0;
      check("lhu_wb_data", wb_data, 32'h0000_8001);
      step();

      // LH lower half: sign-extended.
      issue(1'b1, 1'b0, 3'd1, 32'h0000_3000, 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'h1234_F00D;
      step();
      bus_ack = 1'b0;
      check("lh_wb_data", wb_data, 32'hFFFF_F00D);
      step();

      // LBU lane 1: zero-extended.
      issue(1'b1, 1'b0, 3'd4, 32'h0000_3001, 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'h0000_9A00;
      step();
      bus_ack = 1'b0;
      check("lbu_wb_data", wb_data, 32'h0000_009A);
      step();

      // Misaligned LW: error with no bus traffic.
      issue(1'b1, 1'b0, 3'd2, 32'h8000_0001, 32'd0);
      check("lw_mis_no_req", {31'd0, bus_req},   32'd0);
      check("lw_mis_valid",  {31'd0, out_valid}, 32'd1);
      check("lw_mis_err",    {31'd0, lsu_err},   32'd1);
      check("lw_mis_wb",     wb_data,            32'd0);
      step();

      // Reserved load funct3.
      issue(1'b1, 1'b0, 3'd3, 32'h0000_0000, 32'd0);
      check("rsv_ld_err",    {31'd0, lsu_err}, 32'd1);
      check("rsv_ld_no_req", {31'd0, bus_req}, 32'd0);
      step();

      // Store with a load-only funct3.
      issue(1'b0, 1'b1, 3'd4, 32'h0000_0000, 32'd0);
      check("rsv_st_err", {31'd0, lsu_err}, 32'd1);
      step();

      // Load and store together.
      issue(1'b1, 1'b1, 3'd0, 32'h0000_0000, 32'd0);
      check("ren_wen_err", {31'd0, lsu_err}, 32'd1);
      step();

      // Pass-through with writeback stalled for three cycles.
      out_ready = 1'b0;
      issue(1'b0, 1'b0, 3'd0, 32'h0000_0055, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("np_valid_held", {31'd0, out_valid}, 32'd1);
         check("np_wb_stable",  wb_data,            32'h0000_0055);
         check("np_in_ready",   {31'd0, in_ready},  32'd0);
         check("np_err",        {31'd0, lsu_err},   32'd0);
         step();
      end
      // New op offered during the release cycle must wait for IDLE.
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      alu_result = 32'h0000_0077;
      step();
      check("np_release_idle", {31'd0, out_valid}, 32'd0);
      check("np_release_wb",   wb_data,            32'h0000_0055);
      step();
      in_valid = 1'b0;
      check("np_next_valid", {31'd0, out_valid}, 32'd1);
      check("np_next_wb",    wb_data,            32'h0000_0077);
      step();

      // Reset in the third BUS cycle of an outstanding load; ack arrives late.
      issue(1'b1, 1'b0, 3'd2, 32'h8000_0010, 32'd0);
      check("rst_mid_req", {31'd0, bus_req}, 32'd1);
      step();
      step();
      rst = 1'b1;
      #1;
      check("rst_mid_req_drop", {31'd0, bus_req},  32'd0);
      check("rst_mid_idle",     {31'd0, in_ready}, 32'd1);
      check("rst_mid_addr",     bus_addr,          32'd0);
      #2;
      rst = 1'b0;
      step();
      bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
      step();
      bus_ack = 1'b0;
      check("late_ack_no_valid", {31'd0, out_valid}, 32'd0);
      check("late_ack_no_req",   {31'd0, bus_req},   32'd0);
      check("late_ack_wb",       wb_data,            32'd0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
